uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Buffered 8N1 UART transmitter; the TX counterpart of the board's UART receiver.
//  Bytes are written into a small FIFO, serialised LSB first on o_uart_tx, and
//  echoed to the host PC (key echo, score/status messages) from the snake top level.
// PARAMETERS
//  CLK_FREQ   25_000_000  input clock frequency in Hz
//  BAUD_RATE  115200      line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, truncated (217 at defaults)
//  FIFO_AW    2           FIFO address width; depth = 2**FIFO_AW entries (4 at default)
// PORTS
//  clk         in   1  system clock; every register clocked on its rising edge
//  rst         in   1  synchronous reset, active high
//  i_wr        in   1  write strobe; accepted on a rising edge only when o_full == 0
//  i_data      in   8  byte to send, sampled with i_wr
//  o_full      out  1  FIFO holds 2**FIFO_AW entries
//  o_empty     out  1  FIFO holds 0 entries
//  o_busy      out  1  FSM not in IDLE, or FIFO not empty
//  o_overflow  out  1  sticky; set when i_wr is asserted while o_full == 1; cleared only by rst
//  o_uart_tx   out  1  serial line, registered, idle high
// BEHAVIOUR
//  Reset values: o_uart_tx=1, o_full=0, o_empty=1, o_busy=0, o_overflow=0; FSM=IDLE; FIFO pointers=0.
//  Reset mid-frame aborts the frame: o_uart_tx reads 1 from the edge after rst; FIFO contents are discarded.
//  FIFO: registered count/pointers. A write while full is dropped even if a pop occurs
//   in the same cycle. Pointers wrap modulo depth. Simultaneous push and pop leaves
//   the count unchanged.
//  Baud counter: counts 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT clocks.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP.
//   IDLE:  line=1; if FIFO not empty, pop the head into the shift register -> START.
//   START: line=0 for one bit time -> DATA.
//   DATA:  8 bit times, shift register LSB first; bit index 0..7 -> PARITY if enabled, else STOP.
//   STOP:  line=1 for one bit time; at its last clock, pop and go to START if the FIFO is
//          not empty (no idle gap between frames), otherwise go to IDLE.
//  Latency: byte written at edge N into an empty FIFO with the FSM idle -> popped at edge N+1;
//   o_uart_tx low from edge N+2.
//  Frame length: 10*CLKS_PER_BIT clocks (11*CLKS_PER_BIT with parity).
//  o_busy falls on the edge where STOP ends with the FIFO empty.
//  i_data is ignored when i_wr=0. A pop is never taken from an empty FIFO.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA; sends the even-parity
//   bit (XOR of the 8 data bits) for one bit time; frame becomes 8E1, 11 bits.
//  Not defined: PARITY state and its logic are absent; frame is 8N1, 10 bits.
// TESTING
//  1. Idle, write 0x41 at edge N -> line low over [N+2, N+219), then data bits
//     1,0,0,0,0,0,1,0 at 217 clocks each, then stop=1; o_busy=0 after 2170 clocks of frame.
//  2. Six writes on consecutive edges N..N+5 -> byte1 popped at N+1; o_full=1 after N+4;
//     byte6 dropped, o_overflow=1; bytes 1-5 sent back-to-back with no idle gap.
//  3. Assert rst during DATA bit 3 -> o_uart_tx=1 next edge; o_empty=1, o_busy=0,
//     o_overflow=0; a following write of 0x55 transmits a clean frame.
//  4. With UART_TX_PARITY_EN defined: 0x41 -> parity bit 0; 0x07 -> parity bit 1;
//     frame 11*217 clocks. Without it, 0x07 frame is 10*217 clocks.
//  5. CLK_FREQ=8, BAUD_RATE=1 (CLKS_PER_BIT=8): write 0xA5 -> 80-clock frame,
//     pattern 0,1,0,1,0,0,1,0,1,1 sampled at bit centres.
//  6. Loopback into the board UART receiver at defaults: send 0x00..0xFF
//     -> every received byte equals the byte sent, o_overflow stays 0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter.
// Bytes written with i_wr go into a small FIFO and are sent LSB first on
// o_uart_tx, framed as 8N1 (start bit, 8 data bits, stop bit).
// Optional feature macro: UART_TX_PARITY_EN -- when defined, an even-parity
// bit is inserted after the data bits and the frame becomes 8E1 (11 bits).
//
// Handshake: a write is accepted on a rising edge of clk when i_wr == 1 and
// o_full == 0; a write while o_full == 1 is dropped and sets the sticky
// o_overflow flag. There is no backpressure on the serial side.
module uart_tx #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int BAUD_RATE = 115200,
   parameter int FIFO_AW   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_busy,
   output logic       o_overflow,
   output logic       o_uart_tx
);

   // Integer division truncates, which is the intended bit period.
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int DEPTH        = 1 << FIFO_AW;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]      LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // FIFO storage and bookkeeping
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               push;
   logic               pop;
   logic [7:0]         head;

   // Transmit FSM state
   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic               tx;
`ifdef UART_TX_PARITY_EN
   logic               par;
`endif

   assign o_full     = (count == FULL_CNT);
   assign o_empty    = (count == '0);
   assign o_busy     = (state != IDLE) || !o_empty;
   assign o_uart_tx  = tx;
   assign head       = mem[rd_ptr];

   // A write while full is dropped even if a pop frees a slot this same cycle.
   assign push = i_wr && !o_full;

   // Pop the head when idle, or at the last clock of a stop bit so the next
   // frame follows with no idle gap; never pop an empty FIFO.
   always_comb begin
      pop = 1'b0;
      if (!o_empty) begin
         if (state == IDLE)
            pop = 1'b1;
         else if ((state == STOP) && (cnt == LAST_CNT))
            pop = 1'b1;
      end
   end

   // FIFO data write; contents need no reset because count gates reads.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= i_data;
   end

   // FIFO pointers and occupancy count; pointers wrap modulo the depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag: any write attempt while full.
   always_ff @(posedge clk) begin
      if (rst)
         o_overflow <= 1'b0;
      else if (i_wr && o_full)
         o_overflow <= 1'b1;
   end

   // Frame sequencer; the line register follows the current state, so the
   // line lags state transitions by exactly one clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx  <= 1'b1;
               cnt <= '0;
               if (pop) begin
                  shift <= head;
`ifdef UART_TX_PARITY_EN
                  par   <= ^head;
`endif
                  state <= START;
               end
            end
            START: begin
               tx <= 1'b0;
               if (cnt == LAST_CNT) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               tx <= shift[0];
               if (cnt == LAST_CNT) begin
                  cnt     <= '0;
                  shift   <= shift >> 1;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               tx <= par;
               if (cnt == LAST_CNT) begin
                  cnt   <= '0;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               tx <= 1'b1;
               if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  if (pop) begin
                     shift <= head;
`ifdef UART_TX_PARITY_EN
                     par   <= ^head;
`endif
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// The DUT runs with CLK_FREQ=17, BAUD_RATE=2, so one bit lasts 8 clocks
// (8.5 truncated), keeping frames short.
module tb_uart_tx;

   localparam int CPB  = 8;
   localparam int HALF = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       rst;
   logic       i_wr;
   logic [7:0] i_data;
   logic       o_full;
   logic       o_empty;
   logic       o_busy;
   logic       o_overflow;
   logic       o_uart_tx;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [7:0]  data;
      logic        par;
      logic [10:0] frame;
   } vec_t;

   vec_t vecs [7];

   uart_tx #(
      .CLK_FREQ (17),
      .BAUD_RATE(2),
      .FIFO_AW  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (i_wr),
      .i_data    (i_data),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .o_busy    (o_busy),
      .o_overflow(o_overflow),
      .o_uart_tx (o_uart_tx)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Line bit k of the frame as sent (bit 0 = start bit).
   function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
      return {1'b1, p, d, 1'b0};
`else
      return {1'b0, 1'b1, d, 1'b0};
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      i_wr   = 1'b1;
      i_data = d;
      tick();
      i_wr   = 1'b0;
      i_data = 8'h00;
   endtask

   // Counts clocks until the line goes low; -1 when the budget expires.
   task automatic wait_start(output int lat);
      int i;
      lat = -1;
      i = 0;
      while ((lat < 0) && (i < 40)) begin
         tick();
         i++;
         if (o_uart_tx == 1'b0)
            lat = i;
      end
   endtask

   // Samples NB bits at bit centres; first sample after first_wait clocks.
   task automatic capture(input int first_wait, output logic [10:0] bits);
      bits = '0;
      repeat (first_wait) tick();
      bits[0] = o_uart_tx;
      for (int k = 1; k < NB; k++) begin
         repeat (CPB) tick();
         bits[k] = o_uart_tx;
      end
   endtask

   initial begin
      logic [10:0] bits;
      int          lat;
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b1;
      i_wr   = 1'b0;
      i_data = 8'h00;

      vecs[0] = '{8'h41, 1'b0, 11'h0};
      vecs[1] = '{8'h07, 1'b1, 11'h0};
      vecs[2] = '{8'hA5, 1'b0, 11'h0};
      vecs[3] = '{8'h00, 1'b0, 11'h0};
      vecs[4] = '{8'hFF, 1'b0, 11'h0};
      vecs[5] = '{8'h80, 1'b1, 11'h0};
      vecs[6] = '{8'h55, 1'b0, 11'h0};
      foreach (vecs[i]) vecs[i].frame = exp_frame(vecs[i].data, vecs[i].par);

      // reset values
      repeat (3) tick();
      check("rst_tx",       32'(o_uart_tx),  32'd1);
      check("rst_full",     32'(o_full),     32'd0);
      check("rst_empty",    32'(o_empty),    32'd1);
      check("rst_busy",     32'(o_busy),     32'd0);
      check("rst_overflow", 32'(o_overflow), 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // single frames from idle
      for (int i = 0; i < 7; i++) begin
         write_byte(vecs[i].data);
         check($sformatf("v%0d_empty", i), 32'(o_empty), 32'd0);
         check($sformatf("v%0d_busy",  i), 32'(o_busy),  32'd1);
         wait_start(lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
         capture(HALF, bits);
         check($sformatf("v%0d_frame", i), 32'(bits), 32'(vecs[i].frame));
         repeat (CPB - HALF - 2) tick();
         check($sformatf("v%0d_busy_end", i), 32'(o_busy), 32'd1);
         tick();
         check($sformatf("v%0d_busy_fall", i), 32'(o_busy), 32'd0);
         check($sformatf("v%0d_stop_line", i), 32'(o_uart_tx), 32'd1);
         repeat (3) tick();
      end

      // six back-to-back writes: fill, overflow, five frames without gaps
      for (int i = 0; i < 6; i++) begin
         i_wr   = 1'b1;
         i_data = vecs[i].data;
         tick();
         check($sformatf("b_full_%0d", i),     32'(o_full),     32'(i >= 4));
         check($sformatf("b_overflow_%0d", i), 32'(o_overflow), 32'(i == 5));
      end
      i_wr   = 1'b0;
      i_data = 8'h00;
      check("b_first_start", 32'(o_uart_tx), 32'd0);
      capture(1, bits);
      check("b_frame0", 32'(bits), 32'(vecs[0].frame));
      for (int f = 1; f < 5; f++) begin
         repeat (CPB - HALF - 1) tick();
         check($sformatf("b_stop_%0d", f), 32'(o_uart_tx), 32'd1);
         tick();
         check($sformatf("b_no_gap_%0d", f), 32'(o_uart_tx), 32'd0);
         capture(HALF, bits);
         check($sformatf("b_frame%0d", f), 32'(bits), 32'(vecs[f].frame));
      end
      repeat (CPB - HALF - 2) tick();
      check("b_busy_end", 32'(o_busy), 32'd1);
      tick();
      check("b_busy_fall", 32'(o_busy), 32'd0);
      check("b_overflow_sticky", 32'(o_overflow), 32'd1);
      repeat (3) tick();

      // reset during data bit 3 with bytes still queued
      write_byte(8'h55);
      write_byte(8'h07);
      write_byte(8'h41);
      repeat (HALF + CPB * 4) tick();
      check("c_data_bit3", 32'(o_uart_tx), 32'd0);
      rst = 1'b1;
      tick();
      check("c_tx",       32'(o_uart_tx),  32'd1);
      check("c_empty",    32'(o_empty),    32'd1);
      check("c_busy",     32'(o_busy),     32'd0);
      check("c_overflow", 32'(o_overflow), 32'd0);
      check("c_full",     32'(o_full),     32'd0);
      rst = 1'b0;
      // data with i_wr low must be ignored
      for (int i = 0; i < 6; i++) begin
         i_data = 8'(i * 37 + 1);
         tick();
      end
      i_data = 8'h00;
      check("c_ignored_empty", 32'(o_empty),   32'd1);
      check("c_idle_line",     32'(o_uart_tx), 32'd1);
      write_byte(vecs[6].data);
      wait_start(lat);
      check("c_latency", 32'(lat), 32'd2);
      capture(HALF, bits);
      check("c_frame", 32'(bits), 32'(vecs[6].frame));
      repeat (CPB - HALF - 1) tick();
      check("c_busy_fall", 32'(o_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
